// File: rtl/bdtu_seq.sv
// Block-data-transfer sequencer for LDM/STM.
// It walks the register list one entry per cycle, taking the lowest set bit first, and then writes back the final base.
module bdtu_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_load,
    input  logic              pre,
    input  logic              up,
    input  logic              wb,
    input  logic [3:0]        base_reg,
    input  logic [DATA_W-1:0] base_val,
    input  logic [15:0]       reg_list,
    output logic [3:0]        rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        bdtu_wd1,
    output logic              bdtu_we1,
    output logic [DATA_W-1:0] bdtu_wdata1,
    output logic [3:0]        bdtu_wd2,
    output logic              bdtu_we2,
    output logic [DATA_W-1:0] bdtu_wdata2,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, XFER, FINISH} state_t;

    state_t            state_q, state_d;
    logic [15:0]       list_q, list_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] final_q, final_d;
    logic              is_load_q, is_load_d;
    logic              wb_q, wb_d;
    logic              base_in_q, base_in_d;
    logic [3:0]        base_reg_q, base_reg_d;
    logic              ld_pend_q, ld_pend_d;
    logic [3:0]        ld_reg_q, ld_reg_d;

    logic [4:0]        popcnt;
    logic [3:0]        idx;
    logic [15:0]       list_clr;
    logic [ADDR_W-1:0] n4_a, base_a, start_a;
    logic [DATA_W-1:0] n4_d;

    always_comb begin
        popcnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            popcnt = popcnt + {4'd0, reg_list[i]};
        end
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) idx = i[3:0];
        end
        // Clearing the lowest set bit moves the list to the next register.
        list_clr = list_q & (list_q - 16'd1);
        n4_a     = ADDR_W'({popcnt, 2'b00});
        n4_d     = DATA_W'({popcnt, 2'b00});
        base_a   = ADDR_W'(base_val);
        unique case ({pre, up})
            2'b01:   start_a = base_a;
            2'b11:   start_a = base_a + ADDR_W'(4);
            2'b00:   start_a = base_a - n4_a + ADDR_W'(4);
            default: start_a = base_a - n4_a;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        list_d      = list_q;
        addr_d      = addr_q;
        final_d     = final_q;
        is_load_d   = is_load_q;
        wb_d        = wb_q;
        base_in_d   = base_in_q;
        base_reg_d  = base_reg_q;
        ld_pend_d   = 1'b0;
        ld_reg_d    = ld_reg_q;
        rf_raddr    = 4'd0;
        mem_addr    = '0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        bdtu_we1    = ld_pend_q;
        bdtu_wd1    = ld_pend_q ? ld_reg_q : 4'd0;
        bdtu_wdata1 = ld_pend_q ? mem_rdata : '0;
        bdtu_wd2    = 4'd0;
        bdtu_we2    = 1'b0;
        bdtu_wdata2 = '0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    list_d     = reg_list;
                    addr_d     = {start_a[ADDR_W-1:2], 2'b00};
                    final_d    = up ? base_val + n4_d : base_val - n4_d;
                    is_load_d  = is_load;
                    wb_d       = wb;
                    base_reg_d = base_reg;
                    base_in_d  = reg_list[base_reg];
                    state_d    = (reg_list == 16'd0) ? FINISH : XFER;
                end
            end
            XFER: begin
                busy     = 1'b1;
                mem_addr = addr_q;
                if (is_load_q) begin
                    mem_re    = 1'b1;
                    ld_pend_d = 1'b1;
                    ld_reg_d  = idx;
                end else begin
                    rf_raddr  = idx;
                    mem_we    = 1'b1;
                    mem_wdata = rf_rdata;
                end
                addr_d = addr_q + ADDR_W'(4);
                list_d = list_clr;
                if (list_clr == 16'd0) state_d = FINISH;
            end
            FINISH: begin
                busy        = 1'b1;
                done        = 1'b1;
                bdtu_wd2    = base_reg_q;
                bdtu_wdata2 = final_q;
                // A base register that was loaded keeps the loaded value instead of the writeback.
                bdtu_we2    = wb_q && !(is_load_q && base_in_q);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            list_q     <= '0;
            addr_q     <= '0;
            final_q    <= '0;
            is_load_q  <= 1'b0;
            wb_q       <= 1'b0;
            base_in_q  <= 1'b0;
            base_reg_q <= 4'd0;
            ld_pend_q  <= 1'b0;
            ld_reg_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            list_q     <= list_d;
            addr_q     <= addr_d;
            final_q    <= final_d;
            is_load_q  <= is_load_d;
            wb_q       <= wb_d;
            base_in_q  <= base_in_d;
            base_reg_q <= base_reg_d;
            ld_pend_q  <= ld_pend_d;
            ld_reg_q   <= ld_reg_d;
        end
    end

endmodule

// File: tb/tb_bdtu_seq.sv
// Directed, table-driven bench for bdtu_seq.
// Each vector is checked cycle by cycle; reset and held-start cases are separate hand-written sequences.
module tb_bdtu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, is_load = 1'b0, pre = 1'b0, up = 1'b0, wb = 1'b0;
    logic [3:0]  base_reg = 4'd0;
    logic [31:0] base_val = 32'd0;
    logic [15:0] reg_list = 16'd0;
    logic [3:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [31:0] mem_addr;
    logic        mem_re, mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic [3:0]  bdtu_wd1, bdtu_wd2;
    logic        bdtu_we1, bdtu_we2;
    logic [31:0] bdtu_wdata1, bdtu_wdata2;
    logic        busy, done;

    int total = 0;
    int bad = 0;

    bdtu_seq #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .pre(pre), .up(up), .wb(wb),
        .base_reg(base_reg), .base_val(base_val), .reg_list(reg_list),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .bdtu_wd1(bdtu_wd1), .bdtu_we1(bdtu_we1), .bdtu_wdata1(bdtu_wdata1),
        .bdtu_wd2(bdtu_wd2), .bdtu_we2(bdtu_we2), .bdtu_wdata2(bdtu_wdata2),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Register file and memory stand-ins with recognisable data patterns.
    assign rf_rdata = 32'h1000_0000 | {28'd0, rf_raddr};
    always @(posedge clk) if (mem_re) mem_rdata <= mem_addr ^ 32'hA5A5_0000;

    typedef struct {
        logic        ld, p, u, w;
        logic [3:0]  rn;
        logic [31:0] bv;
        logic [15:0] list;
        logic [31:0] exp_start;
        logic [31:0] exp_final;
        logic        exp_we2;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " we1"}, {31'd0, bdtu_we1}, 32'd0);
        chk({tag, " we2"}, {31'd0, bdtu_we2}, 32'd0);
        chk({tag, " strobes"}, {30'd0, mem_re, mem_we}, 32'd0);
    endtask

    // Issues vector v and checks every cycle of it. With hold set, start stays high afterwards.
    task automatic run_vec(input int v, input bit hold);
        int    regs[16];
        int    n;
        string t;
        n = 0;
        for (int i = 0; i < 16; i++) if (vecs[v].list[i]) begin regs[n] = i; n++; end
        @(negedge clk);
        is_load = vecs[v].ld; pre = vecs[v].p; up = vecs[v].u; wb = vecs[v].w;
        base_reg = vecs[v].rn; base_val = vecs[v].bv; reg_list = vecs[v].list;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int k = 0; k < n; k++) begin
            t = $sformatf("v%0d c%0d", v, k + 1);
            chk({t, " busy"}, {31'd0, busy}, 32'd1);
            chk({t, " done"}, {31'd0, done}, 32'd0);
            chk({t, " addr"}, mem_addr, vecs[v].exp_start + 32'(4 * k));
            chk({t, " re"}, {31'd0, mem_re}, {31'd0, vecs[v].ld});
            chk({t, " we"}, {31'd0, mem_we}, {31'd0, !vecs[v].ld});
            if (!vecs[v].ld) begin
                chk({t, " raddr"}, {28'd0, rf_raddr}, 32'(regs[k]));
                chk({t, " wdata"}, mem_wdata, 32'h1000_0000 | 32'(regs[k]));
            end
            chk({t, " we1"}, {31'd0, bdtu_we1}, {31'd0, vecs[v].ld && k > 0});
            if (vecs[v].ld && k > 0) begin
                chk({t, " wd1"}, {28'd0, bdtu_wd1}, 32'(regs[k-1]));
                chk({t, " wdata1"}, bdtu_wdata1, (vecs[v].exp_start + 32'(4 * (k - 1))) ^ 32'hA5A5_0000);
            end
            @(negedge clk);
        end
        t = $sformatf("v%0d fin", v);
        chk({t, " busy"}, {31'd0, busy}, 32'd1);
        chk({t, " done"}, {31'd0, done}, 32'd1);
        chk({t, " strobes"}, {30'd0, mem_re, mem_we}, 32'd0);
        chk({t, " we1"}, {31'd0, bdtu_we1}, {31'd0, vecs[v].ld && n > 0});
        if (vecs[v].ld && n > 0) begin
            chk({t, " wd1"}, {28'd0, bdtu_wd1}, 32'(regs[n-1]));
            chk({t, " wdata1"}, bdtu_wdata1, (vecs[v].exp_start + 32'(4 * (n - 1))) ^ 32'hA5A5_0000);
        end
        chk({t, " we2"}, {31'd0, bdtu_we2}, {31'd0, vecs[v].exp_we2});
        if (vecs[v].exp_we2) begin
            chk({t, " wd2"}, {28'd0, bdtu_wd2}, {28'd0, vecs[v].rn});
            chk({t, " wdata2"}, bdtu_wdata2, vecs[v].exp_final);
        end
        @(negedge clk);
        chk_quiet($sformatf("v%0d idle", v));
        $display("vec %0d ld=%0d list=%h base=%h n=%0d", v, vecs[v].ld, vecs[v].list, vecs[v].bv, n);
    endtask

    initial begin
        //                ld    p     u     w     rn     base          list      start         final         we2
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd4,  32'h0000_0100, 16'h0026, 32'h0000_0100, 32'h0000_010C, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd6,  32'h0000_0200, 16'h0009, 32'h0000_01F8, 32'h0000_01F8, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  32'h0000_0300, 16'h0014, 32'h0000_0300, 32'h0000_0308, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd7,  32'h0000_0400, 16'h0000, 32'h0000_0000, 32'h0000_0400, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd13, 32'h0000_1000, 16'h8002, 32'h0000_1004, 32'h0000_1008, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1,  32'h0000_0050, 16'h000F, 32'h0000_0044, 32'h0000_0040, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd9,  32'h0000_0004, 16'h0003, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd3,  32'h0000_0103, 16'h0008, 32'h0000_0100, 32'h0000_0107, 1'b0};

        #12;
        chk_quiet("reset");
        chk("reset addr", mem_addr, 32'd0);
        chk("reset wdata2", bdtu_wdata2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) run_vec(v, 1'b0);

        // Reset asserted during the second XFER cycle of a 4-register LDM.
        @(negedge clk);
        is_load = 1'b1; pre = 1'b0; up = 1'b1; wb = 1'b1;
        base_reg = 4'd8; base_val = 32'h0000_0800; reg_list = 16'h000F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst c1 re", {31'd0, mem_re}, 32'd1);
        @(negedge clk);
        chk("rst c2 we1", {31'd0, bdtu_we1}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_quiet("rst now");
        chk("rst now addr", mem_addr, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk_quiet($sformatf("rst hold%0d", c));
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("rst after");
        $display("reset mid-transfer sequence");
        run_vec(0, 1'b0);

        // start held high for the whole transfer: it is ignored while busy and re-accepted in the IDLE cycle after done.
        run_vec(0, 1'b1);
        begin
            bit seen;
            chk("hold restart busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
            start = 1'b0;
            chk("hold restart we", {31'd0, mem_we}, 32'd1);
            chk("hold restart addr", mem_addr, 32'h0000_0100);
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            chk("hold restart done seen", {31'd0, seen}, 32'd1);
            @(negedge clk);
            chk_quiet("hold end");
            $display("held-start sequence");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
